piso_tx_sequencer: RTL and testbench

//  Sequences a parallel-in/serial-out shift register into one timed serial frame per word.

---
 rtl/piso_tx_pkg.sv | 15 +
 rtl/piso_tx_sequencer_timer.sv | 36 +++
 rtl/piso_tx_sequencer.sv | 98 +++++++++
 tb/tb_piso_tx_sequencer.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/piso_tx_pkg.sv
// Shared types and constants for the PISO transmit sequencer.
// State encoding and PISO mode values.
package piso_tx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } piso_tx_state_t;

  localparam logic PISO_MODE_LOAD  = 1'b0;
  localparam logic PISO_MODE_SHIFT = 1'b1;

endpackage

// File: rtl/piso_tx_sequencer_timer.sv
// Bit-period divider: counts CLK cycles within one serial bit.
// tc_o marks the last cycle of the period.
module bit_period_timer #(
  parameter int DIV = 8
) (
  input  logic CLK,
  input  logic n_Reset,
  input  logic clr_i,
  input  logic start_i,
  output logic tc_o
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [W-1:0] div_cnt_q, div_cnt_d;

  assign tc_o = (div_cnt_q == W'(DIV - 1));

  always_comb begin
    div_cnt_d = div_cnt_q;
    if (clr_i) begin
      div_cnt_d = '0;
    end else if (start_i) begin
      div_cnt_d = tc_o ? '0 : div_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge n_Reset) begin
    if (!n_Reset) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

endmodule

// File: rtl/piso_tx_sequencer.sv
// Frames one handshaked word into timed load/shift commands
// for a downstream parallel-in/serial-out register.
module piso_tx_sequencer #(
  parameter int N   = 4,
  parameter int DIV = 8
) (
  input  logic         CLK,
  input  logic         n_Reset,
  input  logic         TX_VALID,
  input  logic [N-1:0] TX_DATA,
  output logic         TX_READY,
  output logic         PISO_EN,
  output logic         PISO_SHIFT,
  output logic [N-1:0] PISO_DATAW,
  output logic         BUSY,
  output logic         DONE
);

  import piso_tx_pkg::piso_tx_state_t;
  import piso_tx_pkg::IDLE;
  import piso_tx_pkg::LOAD;
  import piso_tx_pkg::HOLD;
  import piso_tx_pkg::PISO_MODE_LOAD;
  import piso_tx_pkg::PISO_MODE_SHIFT;

  localparam int BW = $clog2(N);

  piso_tx_state_t state_q, state_d;
  logic [N-1:0]   data_q, data_d;
  logic [BW-1:0]  bit_cnt_q, bit_cnt_d;
  logic           tmr_clr;
  logic           tmr_run;
  logic           tc;
  logic           shift_now;

  bit_period_timer #(
    .DIV (DIV)
  ) u_timer (
    .CLK     (CLK),
    .n_Reset (n_Reset),
    .clr_i   (tmr_clr),
    .start_i (tmr_run),
    .tc_o    (tc)
  );

  assign tmr_run = (state_q == HOLD);

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    bit_cnt_d = bit_cnt_q;
    tmr_clr   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (TX_VALID) begin
          data_d    = TX_DATA;
          bit_cnt_d = '0;
          tmr_clr   = 1'b1;
          state_d   = LOAD;
        end
      end
      LOAD: state_d = HOLD;
      HOLD: begin
        if (tc) begin
          if (bit_cnt_q == BW'(N - 1)) begin
            state_d = piso_tx_pkg::DONE;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      piso_tx_pkg::DONE: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge n_Reset) begin
    if (!n_Reset) begin
      state_q   <= IDLE;
      data_q    <= '0;
      bit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  // Shift is issued on the final cycle of each bit period
  assign shift_now  = (state_q == HOLD) && tc;

  assign TX_READY   = (state_q == IDLE);
  assign BUSY       = (state_q == LOAD) || (state_q == HOLD);
  assign DONE       = (state_q == piso_tx_pkg::DONE);
  assign PISO_EN    = (state_q == LOAD) || shift_now;
  assign PISO_SHIFT = shift_now ? PISO_MODE_SHIFT : PISO_MODE_LOAD;
  assign PISO_DATAW = data_q;

endmodule

// File: tb/tb_piso_tx_sequencer.sv
// Bench: sequencers driving small PISO registers, checked
// on the serial line against timing derived from the frame rules.
module tb_piso_tx_sequencer;

  localparam int NB = 4;
  localparam int DV = 4;
  localparam int FR = NB * DV;

  logic          clk = 1'b0;
  logic          n_rst = 1'b0;
  logic          tx_valid = 1'b0;
  logic          tx_valid1 = 1'b0;
  logic [NB-1:0] tx_data = '0;

  logic          rdy, en, sh, busy, done;
  logic [NB-1:0] dw;
  logic          rdy1, en1, sh1, busy1, done1;
  logic [NB-1:0] dw1;

  logic [NB-1:0] piso_q, piso1_q;
  logic          ser, ser1;

  int cyc = 0;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  piso_tx_sequencer #(.N(NB), .DIV(DV)) u_dut (
    .CLK        (clk),
    .n_Reset    (n_rst),
    .TX_VALID   (tx_valid),
    .TX_DATA    (tx_data),
    .TX_READY   (rdy),
    .PISO_EN    (en),
    .PISO_SHIFT (sh),
    .PISO_DATAW (dw),
    .BUSY       (busy),
    .DONE       (done)
  );

  piso_tx_sequencer #(.N(NB), .DIV(1)) u_dut1 (
    .CLK        (clk),
    .n_Reset    (n_rst),
    .TX_VALID   (tx_valid1),
    .TX_DATA    (tx_data),
    .TX_READY   (rdy1),
    .PISO_EN    (en1),
    .PISO_SHIFT (sh1),
    .PISO_DATAW (dw1),
    .BUSY       (busy1),
    .DONE       (done1)
  );

  // PISO registers: load or shift right with zero fill, LSB out
  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      piso_q  <= '0;
      piso1_q <= '0;
    end else begin
      if (en)  piso_q  <= sh  ? {1'b0, piso_q[NB-1:1]}  : dw;
      if (en1) piso1_q <= sh1 ? {1'b0, piso1_q[NB-1:1]} : dw1;
    end
  end

  assign ser  = piso_q[0];
  assign ser1 = piso1_q[0];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic wait_ready();
    bit ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (rdy) begin
        ok = 1'b1;
        break;
      end
    end
    chk("ready_wait", 32'(ok), 32'd1);
  endtask

  task automatic run_frame(input logic [NB-1:0] w, input logic [FR-1:0] exp);
    logic [FR-1:0] sv = '0;
    logic dseen = 1'b0;
    wait_ready();
    tx_valid = 1'b1;
    tx_data  = w;
    @(negedge clk);
    tx_valid = 1'b0;
    chk("load_cycle", 32'({busy, en, sh, rdy, dw}), 32'({4'b1100, w}));
    for (int i = 0; i < FR; i++) begin
      @(negedge clk);
      sv[i] = ser;
      dseen |= done;
      if (i == 3) tx_data = ~w;
    end
    chk("serial", 32'(sv), 32'(exp));
    chk("no_early_done", 32'(dseen), 32'd0);
    @(negedge clk);
    chk("done_t18", 32'({done, busy, rdy, ser}), 32'b1000);
    @(negedge clk);
    chk("ready_t19", 32'({done, rdy, ser}), 32'b010);
  endtask

  typedef struct {
    logic [NB-1:0] w;
    logic [FR-1:0] exp;
  } vec_t;

  vec_t tbl[6];

  initial begin
    logic [FR-1:0] sv1, sv2;
    logic [5:0]    env, dnv;
    logic [3:0]    s1v;
    logic          rany, dany;
    int            th, c;
    logic [NB-1:0] mw, d;
    logic          v, e_rdy, e_busy, e_done, e_ser;

    tbl[0] = '{4'hB, 16'hF0FF};
    tbl[1] = '{4'hA, 16'hF0F0};
    tbl[2] = '{4'h5, 16'h0F0F};
    tbl[3] = '{4'h3, 16'h00FF};
    tbl[4] = '{4'h8, 16'hF000};
    tbl[5] = '{4'hF, 16'hFFFF};

    repeat (2) @(negedge clk);
    chk("reset_state", 32'({rdy, en, sh, dw, busy, done}), 32'({3'b100, 4'h0, 2'b00}));
    n_rst = 1'b1;

    for (int i = 0; i < 6; i++) run_frame(tbl[i].w, tbl[i].exp);

    // Back-to-back: TX_VALID held high across two frames
    wait_ready();
    tx_valid = 1'b1;
    tx_data  = 4'hA;
    rany = 1'b0;
    sv1  = '0;
    sv2  = '0;
    for (int i = 1; i <= 18; i++) begin
      @(negedge clk);
      if (i == 1) tx_data = 4'h5;
      rany |= rdy;
      if (i >= 2 && i <= 17) sv1[i-2] = ser;
    end
    chk("b2b_ready_low", 32'(rany), 32'd0);
    chk("b2b_serial_a", 32'(sv1), 32'hF0F0);
    @(negedge clk);
    chk("b2b_ready_t19", 32'(rdy), 32'd1);
    @(negedge clk);
    tx_valid = 1'b0;
    chk("b2b_load_t20", 32'({busy, en, sh}), 32'b110);
    for (int i = 0; i < FR; i++) begin
      @(negedge clk);
      sv2[i] = ser;
    end
    chk("b2b_serial_5", 32'(sv2), 32'h0F0F);
    @(negedge clk);
    chk("b2b_done_t37", 32'(done), 32'd1);

    // Reset in the middle of a frame
    wait_ready();
    tx_valid = 1'b1;
    tx_data  = 4'hF;
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (6) @(negedge clk);
    n_rst = 1'b0;
    #1;
    chk("rst_mid", 32'({busy, en, rdy, done, ser}), 32'b00100);
    dany = 1'b0;
    repeat (3) begin
      @(negedge clk);
      dany |= done | busy;
    end
    chk("rst_hold_idle", 32'({dany, rdy}), 32'b01);
    n_rst = 1'b1;
    @(negedge clk);
    chk("rst_no_done", 32'(done), 32'd0);
    run_frame(4'h3, 16'h00FF);

    // DIV=1 instance
    @(negedge clk);
    chk("div1_ready", 32'(rdy1), 32'd1);
    tx_valid1 = 1'b1;
    tx_data   = 4'b0110;
    env = '0;
    dnv = '0;
    s1v = '0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      tx_valid1 = 1'b0;
      env[i-1] = en1;
      dnv[i-1] = done1;
      if (i >= 2 && i <= 5) s1v[i-2] = ser1;
    end
    chk("div1_en", 32'(env), 32'b011111);
    chk("div1_done", 32'(dnv), 32'b100000);
    chk("div1_serial", 32'(s1v), 32'b0110);

    // Random traffic against a frame-timing reference
    n_rst = 1'b0;
    @(negedge clk);
    n_rst = 1'b1;
    th = -1000;
    mw = '0;
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      c = cyc;
      e_rdy  = !(c >= th + 1 && c <= th + 2 + FR);
      e_busy = (c >= th + 1 && c <= th + 1 + FR);
      e_done = (c == th + 2 + FR);
      e_ser  = 1'b0;
      if (c >= th + 2 && c <= th + 1 + FR) e_ser = mw[(c - th - 2) / DV];
      chk("rand", 32'({rdy, busy, done, ser}), 32'({e_rdy, e_busy, e_done, e_ser}));
      v = ($urandom_range(0, 3) == 0);
      d = NB'($urandom);
      tx_valid = v;
      tx_data  = d;
      if (v && e_rdy) begin
        th = c;
        mw = d;
      end
    end
    tx_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
